// File: rtl/bird_draw_datapath.sv
// bird_draw_datapath: bird position, fall/escape animation and one-pixel-per-clock box erase/redraw.
// Optional BIRD_OUTLINE_EN: DRAW paints the box border white.
module bird_draw_datapath #(
  parameter int START_X = 80,
  parameter int START_Y = 100,
  parameter int BIRD_W = 8,
  parameter int BIRD_H = 8,
  parameter int STEP = 2,
  parameter int FALL_STEP = 4,
  parameter int SCR_W = 160,
  parameter int SCR_H = 120,
  parameter logic [2:0] BG_COLOR = 3'b011,
  parameter logic [2:0] BIRD_COLOR = 3'b000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] state,
  output logic       done_drawing,
  output logic       flying,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot
);
  localparam logic [3:0] S_HOLD = 4'd0, S_CLEAR = 4'd1, S_UL = 4'd2, S_UR = 4'd3, S_DRAW = 4'd5,
                         S_DR = 4'd6, S_DL = 4'd7, S_SHOT = 4'd8, S_ESC = 4'd9, S_RST = 4'd10;
  localparam logic signed [9:0] XMAX = 10'(SCR_W - BIRD_W);
  localparam logic signed [9:0] YMAX = 10'(SCR_H - BIRD_H);
  localparam logic [8:0] YF = 9'(FALL_STEP);
  localparam logic [8:0] YS = 9'(SCR_H);
  localparam logic [8:0] XS = 9'(SCR_W);
  localparam logic [3:0] PXL = 4'(BIRD_W - 1);
  localparam logic [3:0] PYL = 4'(BIRD_H - 1);
  typedef enum logic [1:0] {NORMAL, FALL, ESCAPE} mode_t;
  logic [3:0] st, prev_state_q, prev_state_d, px_q, px_d, py_q, py_d, cpx, cpy;
  logic [7:0] x_q, x_d, vx_q, vx_d;
  logic [6:0] y_q, y_d, vy_q, vy_d, y_fall, y_esc;
  logic [2:0] col_q, col_d, draw_col;
  logic [8:0] sx, sy, fy;
  logic signed [9:0] dx, dy, nx, ny;
  mode_t mode_q, mode_d;
  logic entry, emit, last, is_move;
  logic vis_q, vis_d, flying_q, flying_d, active_q, active_d, pend_q, pend_d, done_q, done_d, plot_q, plot_d;
  assign st = (state <= S_RST) ? state : S_HOLD;
  assign entry = st != prev_state_q;
  assign prev_state_d = st;
  assign emit = (st == S_CLEAR || st == S_DRAW) && (entry || active_q);
  assign cpx = entry ? '0 : px_q;
  assign cpy = entry ? '0 : py_q;
  assign last = cpx == PXL && cpy == PYL;
  assign sx = {1'b0, x_q} + {5'b0, cpx};
  assign sy = {2'b0, y_q} + {5'b0, cpy};
  assign is_move = st == S_UR || st == S_UL || st == S_DR || st == S_DL;
  assign dx = (st == S_UR || st == S_DR) ? 10'(STEP) : 10'(-STEP);
  assign dy = (st == S_DR || st == S_DL) ? 10'(STEP) : 10'(-STEP);
  assign nx = $signed({2'b0, x_q}) + dx;
  assign ny = $signed({3'b0, y_q}) + dy;
  assign fy = {2'b0, y_q} + YF;
  assign y_fall = fy > YS ? YS[6:0] : fy[6:0];
  assign y_esc = {2'b0, y_q} < YF ? '0 : y_q - YF[6:0];
`ifdef BIRD_OUTLINE_EN
  assign draw_col = (cpx == 4'd0 || cpx == PXL || cpy == 4'd0 || cpy == PYL) ? 3'b111 : BIRD_COLOR;
`else
  assign draw_col = BIRD_COLOR;
`endif
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    mode_d = mode_q;
    vis_d = vis_q;
    flying_d = mode_q == FALL ? ({2'b0, y_q} < YS) : mode_q == ESCAPE ? vis_q : 1'b0;
    if (entry && is_move && mode_q == NORMAL) begin
      x_d = nx[9] ? '0 : nx > XMAX ? XMAX[7:0] : nx[7:0];
      y_d = ny[9] ? '0 : ny > YMAX ? YMAX[6:0] : ny[6:0];
    end
    if (entry && st == S_SHOT) begin
      mode_d = FALL;
      y_d = y_fall;
    end
    // escape visibility is judged on the position before this visit's move
    if (entry && st == S_ESC) begin
      mode_d = ESCAPE;
      y_d = y_esc;
      vis_d = y_q != '0;
    end
    if (entry && st == S_RST) begin
      x_d = 8'(START_X);
      y_d = 7'(START_Y);
      mode_d = NORMAL;
      vis_d = 1'b0;
      flying_d = 1'b0;
    end
  end
  always_comb begin
    px_d = cpx == PXL ? '0 : cpx + 4'd1;
    py_d = cpx == PXL ? cpy + 4'd1 : cpy;
    active_d = emit && !last;
    pend_d = emit && last;
    done_d = !entry && (done_q || pend_q);
    plot_d = emit && sx < XS && sy < YS;
    vx_d = emit ? sx[7:0] : '0;
    vy_d = emit ? sy[6:0] : '0;
    col_d = !emit ? 3'b000 : st == S_DRAW ? draw_col : BG_COLOR;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_state_q <= S_HOLD;
      x_q <= 8'(START_X);
      y_q <= 7'(START_Y);
      mode_q <= NORMAL;
      vis_q <= 1'b0;
      flying_q <= 1'b0;
      px_q <= '0;
      py_q <= '0;
      active_q <= 1'b0;
      pend_q <= 1'b0;
      done_q <= 1'b0;
      plot_q <= 1'b0;
      vx_q <= '0;
      vy_q <= '0;
      col_q <= '0;
    end else begin
      prev_state_q <= prev_state_d;
      x_q <= x_d;
      y_q <= y_d;
      mode_q <= mode_d;
      vis_q <= vis_d;
      flying_q <= flying_d;
      px_q <= px_d;
      py_q <= py_d;
      active_q <= active_d;
      pend_q <= pend_d;
      done_q <= done_d;
      plot_q <= plot_d;
      vx_q <= vx_d;
      vy_q <= vy_d;
      col_q <= col_d;
    end
  end
  // done is masked in the first cycle of any new state, before the register catches up
  assign done_drawing = done_q && !entry;
  assign flying = flying_q;
  assign vga_plot = plot_q;
  assign vga_x = vx_q;
  assign vga_y = vy_q;
  assign vga_colour = col_q;
endmodule

// File: tb/tb_bird_draw_datapath.sv
// tb_bird_draw_datapath: directed checks of passes, moves, clamping, clipping, fall/escape and aborts.
module tb_bird_draw_datapath;
  localparam logic [3:0] HOLD = 4'd0, CLEAR = 4'd1, UL = 4'd2, UR = 4'd3, DRAW = 4'd5,
                         DR = 4'd6, DL = 4'd7, SHOT = 4'd8, ESC = 4'd9, RST = 4'd10;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [3:0] state = HOLD, state2 = HOLD;
  logic done, fly, plot, done2, fly2, plot2;
  logic [7:0] vx, vx2;
  logic [6:0] vy, vy2;
  logic [2:0] col, col2;
  int n_asrt = 0, n_fail = 0;
  always #5 clk = ~clk;
  bird_draw_datapath dut (.clk(clk), .reset_n(reset_n), .state(state), .done_drawing(done), .flying(fly),
    .vga_x(vx), .vga_y(vy), .vga_colour(col), .vga_plot(plot));
  bird_draw_datapath #(.START_X(156)) dut2 (.clk(clk), .reset_n(reset_n), .state(state2), .done_drawing(done2),
    .flying(fly2), .vga_x(vx2), .vga_y(vy2), .vga_colour(col2), .vga_plot(plot2));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_asrt++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic mv(input logic [3:0] st);
    @(negedge clk) state = st;
    @(negedge clk) state = HOLD;
  endtask
  task automatic pass(input bit sel, input logic [3:0] st, input int ex, input int ey);
    int px, py;
    bit ep;
    logic [2:0] ec;
    @(negedge clk);
    if (sel) state2 = st; else state = st;
    #1 chk("entry_done", sel ? done2 : done, 0);
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      px = i % 8;
      py = i / 8;
      ep = (ex + px < 160) && (ey + py < 120);
      ec = (st == CLEAR) ? 3'b011 : 3'b000;
`ifdef BIRD_OUTLINE_EN
      if (st == DRAW && (px == 0 || px == 7 || py == 0 || py == 7)) ec = 3'b111;
`endif
      chk("plot", sel ? plot2 : plot, ep);
      chk("busy_done", sel ? done2 : done, 0);
      if (ep) begin
        chk("vga_x", sel ? vx2 : vx, ex + px);
        chk("vga_y", sel ? vy2 : vy, ey + py);
        chk("colour", sel ? col2 : col, ec);
      end
    end
    @(negedge clk);
    chk("done", sel ? done2 : done, 1);
    chk("plot_after", sel ? plot2 : plot, 0);
    @(negedge clk);
    chk("done_held", sel ? done2 : done, 1);
    if (sel) state2 = HOLD; else state = HOLD;
    #1 chk("done_cleared", sel ? done2 : done, 0);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_plot", plot, 0);
    chk("rst_x", vx, 0);
    chk("rst_y", vy, 0);
    chk("rst_col", col, 0);
    chk("rst_done", done, 0);
    chk("rst_fly", fly, 0);
    @(negedge clk) reset_n = 1'b1;
    pass(0, DRAW, 80, 100);
    pass(1, CLEAR, 156, 100);
    mv(UR);
    pass(0, DRAW, 82, 98);
    repeat (34) mv(UR);
    mv(UR);
    mv(UR);
    pass(0, DRAW, 152, 26);
    repeat (14) mv(UL);
    pass(0, DRAW, 124, 0);
    mv(DR);
    mv(DL);
    pass(0, DRAW, 124, 4);
    mv(RST);
    pass(0, DRAW, 80, 100);
    chk("fly_normal", fly, 0);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk) state = SHOT;
      @(negedge clk);
      @(negedge clk) chk("fly_shot", fly, (k < 5) ? 1 : 0);
      state = HOLD;
      if (k == 4) pass(0, CLEAR, 80, 116);
    end
    mv(UR);
    pass(0, DRAW, 80, 120);
    mv(RST);
    @(negedge clk) chk("fly_reset", fly, 0);
    pass(0, DRAW, 80, 100);
    for (int k = 1; k <= 26; k++) begin
      @(negedge clk) state = ESC;
      @(negedge clk);
      @(negedge clk) chk("fly_esc", fly, (k < 26) ? 1 : 0);
      state = HOLD;
    end
    pass(0, DRAW, 80, 0);
    mv(RST);
    @(negedge clk) state = DRAW;
    repeat (5) @(negedge clk);
    chk("leave_plot_on", plot, 1);
    state = HOLD;
    @(negedge clk);
    chk("leave_plot", plot, 0);
    chk("leave_done", done, 0);
    repeat (3) @(negedge clk);
    chk("leave_done_late", done, 0);
    @(negedge clk) state = DRAW;
    repeat (10) @(negedge clk);
    chk("abort_plot_on", plot, 1);
    reset_n = 1'b0;
    #1;
    chk("abort_plot", plot, 0);
    chk("abort_done", done, 0);
    chk("abort_x", vx, 0);
    state = HOLD;
    @(negedge clk) reset_n = 1'b1;
    pass(0, DRAW, 80, 100);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
